// File: rtl/exec_control.sv
// Run/halt/step controller for the DE1 core: key conditioning, control FSM and executed-cycle counter.
// Optional macro STEP_COUNTER_EN builds the saturating step_count register; without it step_count reads 0.
module exec_control_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic CLOCK_50,
   input  logic rst_n,
   input  logic pin_n,
   output logic press
);
   logic [1:0]  sync_q, sync_d;
   logic        deb_q, deb_d;
   logic [15:0] cnt_q, cnt_d;
   logic        press_q, press_d;

   always_comb begin
      sync_d  = {sync_q[0], pin_n};
      deb_d   = deb_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync_q[1] != deb_q) begin
         if (cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
            deb_d   = sync_q[1];
            // only a 1->0 change of the accepted level is a press
            press_d = deb_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         deb_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;
endmodule

module exec_control #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RESET_CYCLES    = 4
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic [3:0]  key_n,
   input  logic        cpu_halt,
   output logic        cpu_en,
   output logic        cpu_reset,
   output logic [1:0]  state,
   output logic [15:0] step_count
);
   typedef enum logic [1:0] {
      S_RESET = 2'b00,
      S_HALT  = 2'b01,
      S_RUN   = 2'b10,
      S_STEP  = 2'b11
   } state_t;

   logic [3:0] press;
   state_t     state_q, state_d;
   logic [7:0] rst_cnt_q, rst_cnt_d;

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_key
         exec_control_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLOCK_50 (CLOCK_50),
            .rst_n    (rst_n),
            .pin_n    (key_n[k]),
            .press    (press[k])
         );
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      if (press[1]) begin
         state_d   = S_RESET;
         rst_cnt_d = '0;
      end else begin
         case (state_q)
            S_RESET: begin
               if (rst_cnt_q == 8'(RESET_CYCLES - 1)) state_d = S_HALT;
               else rst_cnt_d = rst_cnt_q + 8'd1;
            end
            S_RUN:   if (cpu_halt || press[3]) state_d = S_HALT;
            S_HALT: begin
               if (!cpu_halt) begin
                  if (press[3])      state_d = S_RUN;
                  else if (press[2]) state_d = S_STEP;
               end
            end
            default: state_d = S_HALT;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RESET;
         rst_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
      end
   end

   assign state     = state_q;
   assign cpu_en    = state_q[1];
   assign cpu_reset = (state_q == S_RESET);

`ifdef STEP_COUNTER_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      // clearing takes precedence over a same-edge increment
      if (press[1] || press[0])
         cnt_d = '0;
      else if (cpu_en && cnt_q != 16'hFFFF)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign step_count = cnt_q;
`else
   logic unused_clr;
   assign unused_clr = press[0];
   assign step_count = '0;
`endif
endmodule

// File: doc/exec_control.md
# exec_control

Execution controller between the DE1 board keys and the single-cycle processor core. It conditions the four raw active-low KEY inputs: synchronize, debounce, then detect presses. A run/halt/step state machine drives the core's clock-enable and synchronous reset. It also counts executed cycles for display on the HEX digits.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a key level change (range 2..65535)
- RESET_CYCLES, 4, cycles cpu_reset is held high on each RESET entry (range 1..255)
- CLOCK_50  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_n  in  4  raw KEY pins, active-low; [3] run/stop, [2] single step, [1] core reset, [0] clear counter
- cpu_halt  in  1  core reports halt instruction executed; level, synchronous to CLOCK_50
- cpu_en  out  1  core clock-enable; core state advances only on edges where cpu_en=1
- cpu_reset  out  1  active-high synchronous reset to core
- state  out  2  current FSM state code (for LEDR)
- step_count  out  16  cycles executed with cpu_en=1, saturating

## Operation
- Synchronizer: two flops per key, reset value 1 (released).
- Debounce, per key:
  - Debounced level starts at 1.
  - A counter counts consecutive cycles where the synchronized sample differs from the debounced level.
  - Any equal sample clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sample and the counter clears.
- Press event: a one-cycle pulse when the debounced level goes 1→0. Release produces no event. Holding a key gives exactly one event.
- FSM states:
  - RESET=2'b00: cpu_reset=1, cpu_en=0.
  - HALT=2'b01: cpu_en=0.
  - RUN=2'b10: cpu_en=1.
  - STEP=2'b11: cpu_en=1 for exactly one cycle.
- Transitions, evaluated in priority order:
  - Key1 press in any state → RESET.
  - RESET → HALT after RESET_CYCLES cycles.
  - RUN and cpu_halt=1 → HALT.
  - RUN and key3 press → HALT.
  - HALT and key3 press and cpu_halt=0 → RUN.
  - HALT and key2 press and cpu_halt=0 → STEP.
  - STEP → HALT unconditionally.
- Simultaneous events:
  - In HALT, key3 and key2 pressed together: key3 wins (RUN).
  - Any press during RESET other than key1 is dropped.
  - Key1 during RESET restarts the RESET_CYCLES count.
  - All presses are dropped while cpu_halt=1 in HALT, except key1.
- step_count:
  - Increments by 1 on each edge where cpu_en=1.
  - Saturates at 16'hFFFF; no wrap.
  - Clears to 0 on RESET entry and on key0 press. Clear wins over a coincident increment.
- Outputs cpu_en, cpu_reset and state are decoded from registered state only: no combinational path from key_n or cpu_halt.

## Timing
- rst_n low, immediately and asynchronously:
  - state=RESET, cpu_reset=1, cpu_en=0, step_count=0.
  - Synchronizers and debounced levels = 1; debounce counters = 0.
- After rst_n rises: cpu_reset stays 1 for RESET_CYCLES rising edges, then state=HALT with cpu_reset=0.
- key_n falling with the pin then held stable: press pulse occurs exactly 2+DEBOUNCE_CYCLES edges later. The FSM state updates on the following edge.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- STEP lasts exactly one cycle, so step_count increases by exactly 1 per step press.
- cpu_halt rising while in RUN: cpu_en drops on the next edge. The core therefore sees one further enabled edge, the one where HALT is registered.
- rst_n asserted mid-RUN or mid-STEP: outputs go to reset values immediately. No partial step is counted after assertion.

## Configuration
- STEP_COUNTER_EN:
  - Defined: step_count behaves as specified.
  - Undefined: step_count is constant 16'h0000 and the counter register is not synthesized. All other behaviour is identical.

## Test plan
- Reset release, DEBOUNCE_CYCLES=4, RESET_CYCLES=4 → cpu_reset=1 for 4 edges, then state=2'b01, cpu_en=0, step_count=0.
- key_n=4'hB held 20 cycles in HALT, then 4'hF → state visits 2'b11 for one cycle; step_count=1. Repeat twice → step_count=3.
- key_n=4'h7 pulse → RUN; after 10 cycles raise cpu_halt → HALT next edge; step_count=11. Key3 press with cpu_halt=1 → stays HALT.
- 3-cycle low glitch on key_n[3] → no state change. 4-cycle-stable press → RUN exactly 6 edges after the pin fell, plus one edge for the state update.
- In RUN press key_n[1] → state=RESET, step_count=0, cpu_reset high 4 cycles, then HALT. key_n=4'h3 in HALT → RUN (key3 beats key2).
- With STEP_COUNTER_EN undefined, 50 RUN cycles → step_count=0. Press key0 at step_count=16'hFFFF (counter enabled, saturated) → 0 next edge.
